// File: rtl/freq_gate_ctrl_pkg.sv
// Shared definitions for the frequency-meter gate sequencer: FSM states,
// range sizing and the gate-length rule used by the result/display path.
package freq_gate_ctrl_pkg;

  localparam int RANGE_W    = 2;
  localparam int NUM_RANGES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_EVAL   = 3'd4,
    ST_LATCH  = 3'd5
  } state_t;

  // Gate window in clock cycles: each range step shortens the window tenfold.
  function automatic int unsigned gate_len(input int unsigned base,
                                           input logic [RANGE_W-1:0] rng);
    case (rng)
      2'd0:    return base;
      2'd1:    return base / 10;
      2'd2:    return base / 100;
      default: return base / 1000;
    endcase
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_timer.sv
// Loadable down-counter timing the gate window; o_done marks the last enabled
// cycle of the loaded length.
module freq_gate_ctrl_timer #(
  parameter int W = 26
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer: clear -> gate -> settle -> evaluate -> latch, with
// one-step-per-measurement auto-ranging of the gate window.
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int GATE_BASE = 50_000_000,
  parameter int CNT_W     = 14,
  parameter int HI_THR    = 9999,
  parameter int LO_THR    = 900,
  parameter int SETTLE    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic [CNT_W-1:0]   i_cnt_val,
  input  logic               i_cnt_ovf,
  output logic               o_cnt_clr,
  output logic               o_cnt_en,
  output logic               o_latch_stb,
  output logic [RANGE_W-1:0] o_range,
  output logic               o_over_range,
  output logic               o_under_range,
  output logic               o_busy,
  output state_t             o_state
);

  localparam int TW = $clog2(GATE_BASE);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0]   HI_V        = CNT_W'(HI_THR);
  localparam logic [CNT_W-1:0]   LO_V        = CNT_W'(LO_THR);
  localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [RANGE_W-1:0] RANGE_MAX   = RANGE_W'(NUM_RANGES - 1);

  // A count just above HI_THR must still read at least LO_THR one range
  // shorter, otherwise the ranging would ping-pong between two windows.
  if (HI_THR + 1 < 10 * LO_THR) begin : g_thr_check
    $error("freq_gate_ctrl: HI_THR+1 must be at least 10*LO_THR");
  end

  state_t               r_state, w_next;
  logic [RANGE_W-1:0]   r_range;
  logic [SW-1:0]        r_settle;
  logic                 r_over, r_under;
  logic                 w_rng_up, w_rng_dn, w_flag_ld, w_over_n, w_under_n;
  logic                 w_hi, w_lo, w_done;
  logic [TW-1:0]        w_gate_val;

  assign w_gate_val = TW'(gate_len(int'(GATE_BASE), r_range) - 1);
  assign w_hi       = i_cnt_ovf || (i_cnt_val > HI_V);
  assign w_lo       = (i_cnt_val < LO_V);

  freq_gate_ctrl_timer #(.W(TW)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (r_state == ST_CLEAR),
    .i_value (w_gate_val),
    .i_en    (r_state == ST_GATE),
    .o_done  (w_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Dropping i_run anywhere before LATCH abandons the measurement untouched.
  always_comb begin
    w_next    = r_state;
    w_rng_up  = 1'b0;
    w_rng_dn  = 1'b0;
    w_flag_ld = 1'b0;
    w_over_n  = 1'b0;
    w_under_n = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_run) w_next = ST_CLEAR;
      ST_CLEAR:  w_next = i_run ? ST_GATE : ST_IDLE;
      ST_GATE: begin
        if (!i_run)      w_next = ST_IDLE;
        else if (w_done) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!i_run)                        w_next = ST_IDLE;
        else if (r_settle == SETTLE_LAST)  w_next = ST_EVAL;
      end
      ST_EVAL: begin
        if (!i_run) begin
          w_next = ST_IDLE;
        end else if (w_hi && (r_range != RANGE_MAX)) begin
          w_next   = ST_CLEAR;
          w_rng_up = 1'b1;
        end else if (w_hi) begin
          w_next    = ST_LATCH;
          w_flag_ld = 1'b1;
          w_over_n  = 1'b1;
        end else if (w_lo && (r_range != '0)) begin
          w_next   = ST_CLEAR;
          w_rng_dn = 1'b1;
        end else begin
          w_next    = ST_LATCH;
          w_flag_ld = 1'b1;
          w_under_n = (r_range == '0) && (i_cnt_val == '0);
        end
      end
      ST_LATCH:  w_next = i_run ? ST_CLEAR : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Range survives run toggling; flags hold until the next latch strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_range  <= '0;
      r_settle <= '0;
      r_over   <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      if (w_rng_up)      r_range <= r_range + 1'b1;
      else if (w_rng_dn) r_range <= r_range - 1'b1;
      if (w_flag_ld) begin
        r_over  <= w_over_n;
        r_under <= w_under_n;
      end
      r_settle <= (r_state == ST_SETTLE) ? r_settle + 1'b1 : '0;
    end
  end

  // o_latch_stb is a one-cycle strobe; o_range and the flags are valid with it.
  assign o_cnt_clr     = (r_state == ST_CLEAR);
  assign o_cnt_en      = (r_state == ST_GATE);
  assign o_latch_stb   = (r_state == ST_LATCH);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_range       = r_range;
  assign o_over_range  = r_over;
  assign o_under_range = r_under;
  assign o_state       = r_state;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl with a 1000-cycle base gate.
module tb_freq_gate_ctrl;
  import freq_gate_ctrl_pkg::*;

  localparam int GB = 1000;
  localparam int CW = 14;
  localparam int HI = 9999;
  localparam int LO = 900;
  localparam int ST = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic [CW-1:0] cnt_val = '0;
  logic cnt_ovf = 1'b0;
  logic cnt_clr, cnt_en, latch_stb, over_range, under_range, busy;
  logic [1:0] rng;
  state_t state;

  always #10 clk = ~clk;

  freq_gate_ctrl #(.GATE_BASE(GB), .CNT_W(CW), .HI_THR(HI), .LO_THR(LO), .SETTLE(ST)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_cnt_val(cnt_val), .i_cnt_ovf(cnt_ovf),
    .o_cnt_clr(cnt_clr), .o_cnt_en(cnt_en), .o_latch_stb(latch_stb), .o_range(rng),
    .o_over_range(over_range), .o_under_range(under_range), .o_busy(busy), .o_state(state)
  );

  int n_checks = 0;
  int n_pass = 0;

  // reference model state and scoreboard
  int m_range = 0;
  logic [CW-1:0] val_q[$];
  bit ovf_q[$];
  logic [1:0] exp_q[$];
  int exp_cycles, exp_en, exp_meas;
  bit exp_over, exp_under;

  function automatic int glen(input int r);
    return GB / (10 ** r);
  endfunction

  task automatic decide(input int r, input logic [CW-1:0] v, input bit o,
                        output int nr, output bit done, output bit ov, output bit un);
    bit hi;
    hi = o || (int'(v) > HI);
    nr = r; done = 0; ov = 0; un = 0;
    if (hi) begin
      if (r < 3) nr = r + 1;
      else begin done = 1; ov = 1; end
    end else if ((int'(v) < LO) && (r > 0)) begin
      nr = r - 1;
    end else begin
      done = 1;
      un = (v == 0) && (r == 0);
    end
  endtask

  task automatic model_run();
    int r, nr;
    bit d, ov, un, fin;
    r = m_range; fin = 0;
    exp_cycles = 1; exp_en = 0; exp_meas = 0; exp_over = 0; exp_under = 0;
    exp_q.delete();
    foreach (val_q[i]) begin
      if (!fin) begin
        exp_q.push_back(2'(r));
        exp_meas++;
        exp_en += glen(r);
        exp_cycles += 2 + glen(r) + ST;
        decide(r, val_q[i], ovf_q[i], nr, d, ov, un);
        r = nr;
        if (d) begin fin = 1; exp_over = ov; exp_under = un; end
      end
    end
    m_range = r;
  endtask

  task automatic gen_random();
    int r, nr;
    bit d, ov, un, o;
    logic [CW-1:0] v;
    r = m_range;
    val_q.delete(); ovf_q.delete();
    for (int k = 0; k < 8; k++) begin
      o = 0;
      case ($urandom_range(0, 4))
        0:       v = '0;
        1:       v = CW'($urandom_range(1, 899));
        2:       v = CW'($urandom_range(900, 9999));
        3:       v = CW'($urandom_range(10000, 16383));
        default: begin v = CW'($urandom_range(0, 16383)); o = 1; end
      endcase
      if (k == 7) begin v = CW'(5000); o = 0; end
      val_q.push_back(v); ovf_q.push_back(o);
      decide(r, v, o, nr, d, ov, un);
      r = nr;
      if (d) break;
    end
  endtask

  // driver: caller is at a negedge; runs one measurement cycle to latch_stb
  task automatic run_measure(input string name);
    int edges, clrs, ens;
    bit seen;
    logic [CW-1:0] dv[$];
    bit dov[$];
    logic [1:0] got_q[$];
    edges = 0; clrs = 0; ens = 0; seen = 0;
    dv = val_q; dov = ovf_q;
    model_run();
    run = 1'b1;
    while (!seen && edges < 12000) begin
      @(negedge clk);
      edges++;
      if (cnt_clr) begin
        clrs++;
        got_q.push_back(rng);
        if (dv.size() > 0) begin
          cnt_val = dv.pop_front();
          cnt_ovf = dov.pop_front();
        end
      end
      if (cnt_en) ens++;
      if (latch_stb) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL %s latch_stb timeout: got none expected one", name);
    else n_pass++;
    n_checks++;
    if (edges !== exp_cycles) $display("FAIL %s latency: got %0d expected %0d", name, edges, exp_cycles);
    else n_pass++;
    n_checks++;
    if (ens !== exp_en) $display("FAIL %s cnt_en cycles: got %0d expected %0d", name, ens, exp_en);
    else n_pass++;
    n_checks++;
    if (clrs !== exp_meas) $display("FAIL %s cnt_clr pulses: got %0d expected %0d", name, clrs, exp_meas);
    else n_pass++;
    if (got_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL %s range seq[%0d]: got %0d expected %0d", name, i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (rng !== 2'(m_range)) $display("FAIL %s range at latch: got %0d expected %0d", name, rng, m_range);
    else n_pass++;
    n_checks++;
    if (over_range !== exp_over) $display("FAIL %s over_range: got %0b expected %0b", name, over_range, exp_over);
    else n_pass++;
    n_checks++;
    if (under_range !== exp_under) $display("FAIL %s under_range: got %0b expected %0b", name, under_range, exp_under);
    else n_pass++;
  endtask

  task automatic stop_run();
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int clr_seen;
    clr_seen = 0;
    run = 1'b1;
    cnt_val = CW'(5000);
    repeat (5) begin
      @(negedge clk);
      if (cnt_clr || cnt_en || latch_stb || busy) clr_seen++;
    end
    n_checks++;
    if (clr_seen !== 0) $display("FAIL reset activity: got %0d active cycles expected 0", clr_seen);
    else n_pass++;
    n_checks++;
    if ({rng, over_range, under_range} !== 4'b0) $display("FAIL reset outputs: got %b expected 0000", {rng, over_range, under_range});
    else n_pass++;
    n_checks++;
    if (state !== ST_IDLE) $display("FAIL reset state: got %0d expected %0d", state, ST_IDLE);
    else n_pass++;
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    val_q = '{CW'(5000)}; ovf_q = '{1'b0};
    run_measure("basic");
    stop_run();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic idle busy: got %0b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_overflow_ramp();
    val_q.delete(); ovf_q.delete();
    for (int i = 0; i < 4; i++) begin
      val_q.push_back(CW'($urandom_range(0, 16383)));
      ovf_q.push_back(1'b1);
    end
    run_measure("ovf_ramp");
    stop_run();
    n_checks++;
    if (over_range !== 1'b1) $display("FAIL ovf_ramp flag hold: got %0b expected 1", over_range);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    val_q = '{CW'(50), CW'(5000)}; ovf_q = '{1'b0, 1'b0};
    run_measure("down_3to2");
    val_q = '{CW'(50), CW'(5000)}; ovf_q = '{1'b0, 1'b0};
    run_measure("down_2to1");
    val_q = '{CW'(500), CW'(0)}; ovf_q = '{1'b0, 1'b0};
    run_measure("under");
    stop_run();
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      gen_random();
      run_measure($sformatf("rand%0d", i));
    end
    stop_run();
  endtask

  task automatic test_abort();
    int ens, act;
    ens = 0; act = 0;
    val_q = '{CW'(100), CW'(100), CW'(100), CW'(100)}; ovf_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_measure("to_range0");
    stop_run();
    run = 1'b1;
    for (int k = 0; k < 2000 && ens < 300; k++) begin
      @(negedge clk);
      if (cnt_en) ens++;
    end
    n_checks++;
    if (ens !== 300) $display("FAIL abort gate reach: got %0d expected 300", ens);
    else n_pass++;
    run = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cnt_en, busy} !== 2'b00) $display("FAIL abort next cycle: got en/busy %b expected 00", {cnt_en, busy});
    else n_pass++;
    n_checks++;
    if (rng !== 2'(m_range)) $display("FAIL abort range: got %0d expected %0d", rng, m_range);
    else n_pass++;
    repeat (20) begin
      @(negedge clk);
      if (cnt_en || cnt_clr || latch_stb) act++;
    end
    n_checks++;
    if (act !== 0) $display("FAIL abort quiet: got %0d active cycles expected 0", act);
    else n_pass++;
  endtask

  task automatic test_reset_mid_gate();
    int ens;
    ens = 0;
    val_q = '{CW'(0), CW'(5000)}; ovf_q = '{1'b1, 1'b0};
    run_measure("to_range1");
    stop_run();
    run = 1'b1;
    for (int k = 0; k < 500 && ens < 30; k++) begin
      @(negedge clk);
      if (cnt_en) ens++;
    end
    #3 rst_n = 1'b0;
    m_range = 0;
    #1;
    n_checks++;
    if ({cnt_en, busy, latch_stb} !== 3'b000) $display("FAIL async reset outputs: got %b expected 000", {cnt_en, busy, latch_stb});
    else n_pass++;
    n_checks++;
    if (rng !== 2'(m_range)) $display("FAIL async reset range: got %0d expected %0d", rng, m_range);
    else n_pass++;
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state !== ST_IDLE) $display("FAIL post reset state: got %0d expected %0d", state, ST_IDLE);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_ramp();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid_gate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
